// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional performance counter is enabled with the IFU_PERF_CNT_EN macro.
package ifu_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] INST_NOP = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT_RSP,
    DROP
  } ifu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fifo_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Circular instruction buffer holding {pc, inst} entries; DEPTH must be a power of two.
// The caller only pushes when there is room (not full, or popping in the same cycle).
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  fifo_entry_t                data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output fifo_entry_t                data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("ifu_fifo: DEPTH must be a power of two, at least 2");
  end

  fifo_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{PTR_W{1'b0}}, push_i} - {{PTR_W{1'b0}}, do_pop};
    end
  end

  // NOTE: storage is deliberately not reset; the empty flag keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: single-outstanding fetch FSM feeding an instruction buffer.
// Define IFU_PERF_CNT_EN to add the fetch_count retired-fetch counter port.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [63:0] inst_pc,
  input  logic        inst_ready
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            req_fire, push, pop;
  logic            fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fifo_entry_t     push_entry, head;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    req_pc_d       = req_pc_q;
    push           = 1'b0;
    imem_req_valid = (state_q == FETCH) && (fifo_count < CNT_W'(FIFO_DEPTH));
    req_fire       = imem_req_valid && imem_req_ready;

    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (req_fire) begin
          state_d  = WAIT_RSP;
          pc_d     = pc_q + 64'd4;
          req_pc_d = pc_q;
        end
      end
      WAIT_RSP: begin
        if (imem_rsp_valid) begin
          push    = !fifo_full || pop;
          state_d = FETCH;
        end
      end
      DROP:    if (imem_rsp_valid) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    // A redirect overrides everything: an in-flight response is orphaned and must be drained.
    if (redirect_valid) begin
      push = 1'b0;
      pc_d = redirect_pc & ~64'h3;
      case (state_q)
        FETCH:            state_d = req_fire ? DROP : FETCH;
        WAIT_RSP, DROP:   state_d = imem_rsp_valid ? FETCH : DROP;
        default:          state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign imem_req_addr = pc_q;
  assign push_entry    = '{pc: req_pc_q, inst: imem_rsp_data};
  assign inst_valid    = !fifo_empty;
  assign pop           = inst_valid && inst_ready;
  assign inst_data     = fifo_empty ? INST_NOP : head.inst;
  assign inst_pc       = fifo_empty ? '0 : head.pc;

  ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   fetch_count_q <= '0;
    else if (pop) fetch_count_q <= fetch_count_q + 32'd1;
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: vector table, directed corner cases,
// and randomized traffic against a queue-based reference model.
module tb_inst_fetch_unit;
  import ifu_pkg::*;

  localparam logic [63:0] TB_RESET_PC = 64'h0;
  localparam int          DEPTH       = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic        inst_ready = 1'b0;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  inst_fetch_unit #(.RESET_PC(TB_RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered instructions, next fetch pc, and the one outstanding request.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } ment_t;

  ment_t       m_q[$];
  logic [63:0] m_pc;
  logic [63:0] m_out_pc;
  bit          m_boot, m_out, m_killed;
  logic [31:0] m_cnt;

  // Memory stimulus: one pending response delivered a fixed or random number of cycles later.
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_data = '0;
  bit          mem_rand = 0;
  int          mem_dly_max = 1;
  logic [31:0] salt = '0;

  function automatic bit m_req_valid();
    return !m_boot && !m_out && (m_q.size() < DEPTH);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc     = TB_RESET_PC;
    m_out_pc = '0;
    m_boot   = 1;
    m_out    = 0;
    m_killed = 0;
    m_cnt    = '0;
  endtask

  task automatic check_reset_state();
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst_data", inst_data, 64'h13);
    check("rst_inst_pc", inst_pc, 0);
`ifdef IFU_PERF_CNT_EN
    check("rst_fetch_count", fetch_count, 0);
`endif
  endtask

  // Called at a negedge; leaves the bench at a negedge with the DUT in its first post-reset cycle.
  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;
    #1;
    check_reset_state();
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic compare_outputs();
    check("req_valid", imem_req_valid, m_req_valid());
    if (m_req_valid()) check("req_addr", imem_req_addr, m_pc);
    check("inst_valid", inst_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("inst_pc", inst_pc, m_q[0].pc);
      check("inst_data", inst_data, m_q[0].inst);
    end
`ifdef IFU_PERF_CNT_EN
    check("fetch_count", fetch_count, m_cnt);
`endif
  endtask

  task automatic cycle(input bit redir, input logic [63:0] rpc, input bit iready);
    bit          ready, rsp, acc, pop, rsp_used;
    logic [31:0] rdata;
    compare_outputs();
    ready = mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    rsp   = 0;
    rdata = $urandom;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rsp   = 1;
        rdata = mem_data;
      end
    end else if (mem_rand && $urandom_range(0, 7) == 0) begin
      rsp = 1;
    end
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = ready;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rdata;
    inst_ready     = iready;

    if (rsp && mem_pend) mem_pend = 0;
    if (imem_req_valid && ready) begin
      mem_pend = 1;
      mem_cnt  = mem_rand ? $urandom_range(1, mem_dly_max) : mem_dly_max;
      mem_data = (imem_req_addr[31:0] * 32'h9E3779B1) ^ salt;
    end

    acc      = m_req_valid() && ready;
    pop      = (m_q.size() != 0) && iready;
    rsp_used = m_out && rsp;
    if (pop) m_cnt++;
    if (redir) begin
      m_q.delete();
      if (rsp_used) m_out = 0;
      else if (m_out) m_killed = 1;
      if (acc) begin
        m_out    = 1;
        m_killed = 1;
      end
      m_pc = {rpc[63:2], 2'b00};
    end else begin
      if (pop) void'(m_q.pop_front());
      if (rsp_used) begin
        if (!m_killed) m_q.push_back('{pc: m_out_pc, inst: rdata});
        m_out = 0;
      end
      if (acc) begin
        m_out    = 1;
        m_killed = 0;
        m_out_pc = m_pc;
        m_pc     = m_pc + 64'd4;
      end
    end
    m_boot = 0;
    @(negedge clk);
  endtask

  typedef struct {
    logic        ready;
    logic        rsp;
    logic [31:0] rdata;
    logic        iready;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [63:0] e_pc;
    logic [31:0] e_data;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [63:0] got[$];
    logic [63:0] addrs[$];
    bit          found;

    // Always-ready memory answering one cycle after each accept.
    vt[0] = '{1, 0, 32'h0,         1, 0, 64'h0, 0, 64'h0, 32'h0};
    vt[1] = '{1, 0, 32'h0,         1, 1, 64'h0, 0, 64'h0, 32'h0};
    vt[2] = '{1, 1, 32'h1111_0000, 1, 0, 64'h0, 0, 64'h0, 32'h0};
    vt[3] = '{1, 0, 32'h0,         1, 1, 64'h4, 1, 64'h0, 32'h1111_0000};
    vt[4] = '{1, 1, 32'h2222_0004, 1, 0, 64'h0, 0, 64'h0, 32'h0};
    vt[5] = '{1, 0, 32'h0,         1, 1, 64'h8, 1, 64'h4, 32'h2222_0004};
    vt[6] = '{1, 1, 32'h3333_0008, 1, 0, 64'h0, 0, 64'h0, 32'h0};
    vt[7] = '{1, 0, 32'h0,         1, 1, 64'hC, 1, 64'h8, 32'h3333_0008};

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("vec%0d_req_valid", i), imem_req_valid, vt[i].e_req);
      if (vt[i].e_req) check($sformatf("vec%0d_req_addr", i), imem_req_addr, vt[i].e_addr);
      check($sformatf("vec%0d_inst_valid", i), inst_valid, vt[i].e_iv);
      if (vt[i].e_iv) begin
        check($sformatf("vec%0d_inst_pc", i), inst_pc, vt[i].e_pc);
        check($sformatf("vec%0d_inst_data", i), inst_data, vt[i].e_data);
      end
      imem_req_ready = vt[i].ready;
      imem_rsp_valid = vt[i].rsp;
      imem_rsp_data  = vt[i].rdata;
      inst_ready     = vt[i].iready;
      @(negedge clk);
    end

    // Stalled decoder: buffer fills, requests stop, then drains in order.
    mem_pend = 0; mem_rand = 0; mem_dly_max = 1;
    do_reset();
    repeat (12) cycle(0, '0, 0);
    check("stall_req_valid", imem_req_valid, 0);
    check("stall_inst_valid", inst_valid, 1);
    check("stall_head_pc", inst_pc, TB_RESET_PC);
    got.delete();
    for (int i = 0; i < 20 && got.size() < 3; i++) begin
      if (inst_valid) got.push_back(inst_pc);
      cycle(0, '0, 1);
    end
    check("stall_drain_count", got.size(), 3);
    if (got.size() == 3) begin
      check("stall_drain_pc0", got[0], TB_RESET_PC);
      check("stall_drain_pc1", got[1], TB_RESET_PC + 4);
      check("stall_drain_pc2", got[2], TB_RESET_PC + 8);
    end

    // Redirect while waiting: response dropped, fetch restarts at aligned target.
    mem_pend = 0; mem_dly_max = 3;
    do_reset();
    cycle(0, '0, 1);
    cycle(0, '0, 1);
    cycle(1, 64'h1002, 1);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req_valid) begin
        found = 1;
        break;
      end
      cycle(0, '0, 1);
    end
    check("drop_req_seen", found, 1);
    check("drop_req_addr", imem_req_addr, 64'h1000);
    check("drop_inst_valid", inst_valid, 0);

    // Redirect coincident with push and pop, then with pop on a full buffer; pc wraps at 2^64.
    mem_pend = 0; mem_dly_max = 1;
    do_reset();
    repeat (4) cycle(0, '0, 0);
    check("pp_pre_inst_valid", inst_valid, 1);
    cycle(1, 64'h2000, 1);
    check("pp_flush_inst_valid", inst_valid, 0);
    repeat (8) cycle(0, '0, 0);
    check("full_req_valid", imem_req_valid, 0);
    check("full_inst_valid", inst_valid, 1);
    cycle(1, 64'hFFFF_FFFF_FFFF_FFFE, 1);
    check("full_flush_inst_valid", inst_valid, 0);
    addrs.delete();
    for (int i = 0; i < 20 && addrs.size() < 2; i++) begin
      if (imem_req_valid) addrs.push_back(imem_req_addr);
      cycle(0, '0, 1);
    end
    check("wrap_req_count", addrs.size(), 2);
    if (addrs.size() == 2) begin
      check("wrap_addr0", addrs[0], 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_addr1", addrs[1], 64'h0);
    end

    // Reset mid-transaction; the late response lands in FETCH and must be ignored.
    mem_pend = 0; mem_dly_max = 2; salt = 32'hBAD0_0000;
    do_reset();
    cycle(0, '0, 1);
    cycle(0, '0, 1);
    salt = '0;
    do_reset();
    cycle(0, '0, 1);
    check("post_rst_req_valid", imem_req_valid, 1);
    check("post_rst_req_addr", imem_req_addr, TB_RESET_PC);
    repeat (8) cycle(0, '0, 1);

`ifdef IFU_PERF_CNT_EN
    mem_pend = 0; mem_dly_max = 1;
    do_reset();
    for (int i = 0; i < 40 && m_cnt != 5; i++) cycle(0, '0, 1);
    check("perf_model_reached", m_cnt, 5);
    check("perf_fetch_count", fetch_count, 5);
`endif

    // Randomized traffic: random ready, latency, spurious responses, stalls and redirects.
    mem_pend = 0; mem_rand = 1; mem_dly_max = 4;
    do_reset();
    repeat (3000) cycle($urandom_range(0, 19) == 0, {$urandom, $urandom}, $urandom_range(0, 2) != 0);
    compare_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
